norm_shift_16: RTL and testbench
================================

NORM_SHIFT_16 -- requirements
Module: norm_shift_16

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream operand valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts the operand this cycle.
REQ-005 SHALL have port in_mant, input, 16 bits: unnormalized mantissa.
REQ-006 SHALL have port in_exp, input, 8 bits: unsigned biased exponent.
REQ-007 SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-009 SHALL have port out_mant, output, 16 bits: normalized mantissa.
REQ-010 SHALL have port out_exp, output, 8 bits: adjusted exponent.
REQ-011 SHALL have port out_zero, output, 1 bit: in_mant was zero.
REQ-012 SHALL have port out_tiny, output, 1 bit: full normalization was prevented by the exponent floor.

Function
REQ-013 SHALL be a 2-stage pipeline: S1 registers the operand and its leading-zero count; S2 registers the shifted result.
REQ-014 SHALL transfer an input when in_valid & in_ready are both high in the same cycle; an output transfers when out_valid & out_ready are both high.
REQ-015 SHALL drive in_ready = ~s1_valid | s1_adv, where s1_adv = ~s2_valid | out_ready; in_ready is combinational and carries no registered bubble.
REQ-016 SHALL set lzc (5 bits, 0..16) to the number of leading zeros of in_mant, counted from bit 15; lzc = 16 when in_mant = 0.
REQ-017 SHALL set shamt = min(lzc, in_exp).
REQ-018 SHALL set out_mant = in_mant << shamt, truncated to 16 bits.
REQ-019 SHALL set out_exp = in_exp - shamt; this never underflows.
REQ-020 SHALL set out_tiny = (lzc > in_exp) & (in_mant != 0).
REQ-021 SHALL, when in_mant = 0, force out_mant = 0, out_exp = 0, out_zero = 1 and out_tiny = 0.
REQ-022 SHALL produce a latency of exactly 2 cycles from the input transfer to out_valid, given no backpressure.
REQ-023 SHALL sustain a throughput of 1 result per cycle while out_ready is held high.
REQ-024 SHALL, under backpressure (out_valid=1, out_ready=0), hold S2 stable and hold S1 if it is valid; in_ready falls only when both stages are occupied.
REQ-025 SHALL, on a simultaneous output transfer and input transfer with a full pipe, advance all stages in the same cycle with no loss and no duplication.
REQ-026 SHALL keep out_mant, out_exp, out_zero and out_tiny stable while out_valid=1 and out_ready=0.
REQ-027 SHALL preserve input order at the output; the pipeline holds at most 2 results in flight.

Reset
REQ-028 SHALL, on rst=1, asynchronously clear s1_valid and s2_valid; out_valid reads 0 immediately.
REQ-029 SHALL reset out_mant, out_exp, out_zero and out_tiny to 0.
REQ-030 SHALL, if rst is asserted mid-operation, discard in-flight results; no out_valid pulse follows deassertion.
REQ-031 SHALL drive in_ready = 1 during reset and in the first cycle after reset.

Verification
REQ-032 SHALL cover normal normalization: in_mant=16'h00F0, in_exp=8'd20 -> two cycles later out_mant=16'hF000, out_exp=8'd12, out_tiny=0, out_zero=0.
REQ-033 SHALL cover the exponent floor: in_mant=16'h0001, in_exp=8'd3 -> out_mant=16'h0008, out_exp=0, out_tiny=1.
REQ-034 SHALL cover zero: in_mant=0, in_exp=8'd77 -> out_mant=0, out_exp=0, out_zero=1, out_tiny=0.
REQ-035 SHALL cover an already-normalized operand: in_mant=16'h8001, in_exp=8'd0 -> out_mant=16'h8001, out_exp=0, out_tiny=0.
REQ-036 SHALL cover backpressure: stream 4 operands with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, outputs held stable, then 4 results emerge in order with no drops.
REQ-037 SHALL cover reset mid-operation: assert rst with 2 results in flight -> out_valid=0 at once, in_ready=1, and no stale result appears after release.

Source files
------------

// File: rtl/norm_shift_16.sv
// norm_shift_16: two-stage normalizing shifter with valid/ready handshakes.
// S1 captures the operand together with its leading-zero count. S2 captures
// the operand shifted left by min(lzc, exponent) and the adjusted exponent.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (in_ready is combinational)
//   in_mant, in_exp       unnormalized mantissa, unsigned biased exponent
//   out_valid/out_ready   result handshake
//   out_mant, out_exp     normalized mantissa, adjusted exponent
//   out_zero, out_tiny    operand was zero / exponent floor limited the shift
module norm_shift_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_mant,
    input  logic [7:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_mant,
    output logic [7:0]  out_exp,
    output logic        out_zero,
    output logic        out_tiny
);

    localparam int unsigned MW = 16;
    localparam int unsigned EW = 8;
    localparam int unsigned CW = 5;

    logic          s1_valid_q, s1_valid_d;
    logic [MW-1:0] s1_mant_q,  s1_mant_d;
    logic [EW-1:0] s1_exp_q,   s1_exp_d;
    logic [CW-1:0] s1_lzc_q,   s1_lzc_d;

    logic          s2_valid_q, s2_valid_d;
    logic [MW-1:0] s2_mant_q,  s2_mant_d;
    logic [EW-1:0] s2_exp_q,   s2_exp_d;
    logic          s2_zero_q,  s2_zero_d;
    logic          s2_tiny_q,  s2_tiny_d;

    logic          s1_adv;
    logic [CW-1:0] lzc_c;
    logic [CW-1:0] shamt;
    logic          floor_hit;
    logic          s1_zero;

    // S1 may move on when S2 is empty or S2 is draining this cycle.
    assign s1_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s1_adv;

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        lzc_c = CW'(MW);
        for (int i = 0; i < int'(MW); i++) begin
            if (in_mant[i]) lzc_c = CW'(int'(MW) - 1 - i);
        end
    end

    // Shift amount limited by the exponent; exponent < lzc <= 16 here, so it fits.
    always_comb begin
        s1_zero   = (s1_mant_q == '0);
        floor_hit = (EW'(s1_lzc_q) > s1_exp_q);
        shamt     = floor_hit ? s1_exp_q[CW-1:0] : s1_lzc_q;
    end

    // Next-state for both stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_lzc_d   = s1_lzc_q;
        s2_valid_d = s2_valid_q;
        s2_mant_d  = s2_mant_q;
        s2_exp_d   = s2_exp_q;
        s2_zero_d  = s2_zero_q;
        s2_tiny_d  = s2_tiny_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mant_d = in_mant;
                s1_exp_d  = in_exp;
                s1_lzc_d  = lzc_c;
            end
        end

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mant_d = s1_zero ? '0 : MW'(s1_mant_q << shamt);
                s2_exp_d  = s1_zero ? '0 : EW'(s1_exp_q - EW'(shamt));
                s2_zero_d = s1_zero;
                s2_tiny_d = floor_hit & ~s1_zero;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_lzc_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_tiny_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_exp_q   <= s1_exp_d;
            s1_lzc_q   <= s1_lzc_d;
            s2_valid_q <= s2_valid_d;
            s2_mant_q  <= s2_mant_d;
            s2_exp_q   <= s2_exp_d;
            s2_zero_q  <= s2_zero_d;
            s2_tiny_q  <= s2_tiny_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_mant  = s2_mant_q;
    assign out_exp   = s2_exp_q;
    assign out_zero  = s2_zero_q;
    assign out_tiny  = s2_tiny_q;

endmodule

// File: tb/tb_norm_shift_16.sv
// tb_norm_shift_16: directed and randomized checks of norm_shift_16 against an
// arithmetic reference model with an in-order scoreboard.
module tb_norm_shift_16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mant;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_tiny;

    int passed = 0;
    int total  = 0;
    int popped = 0;

    logic [23:0] src[$];   // pending operands {mant, exp}
    logic [25:0] sb[$];    // expected results {mant, exp, zero, tiny}

    norm_shift_16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_tiny  (out_tiny)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor(log2 m) = clog2(m+1)-1, so leading zeros = 16 - clog2(m+1).
    function automatic logic [25:0] model(input logic [15:0] m, input logic [7:0] e);
        int lz;
        int sh;
        int mi;
        int ei;
        mi = int'(m);
        ei = int'(e);
        if (mi == 0) return {16'h0, 8'h0, 1'b1, 1'b0};
        lz = 16 - $clog2(mi + 1);
        sh = (lz < ei) ? lz : ei;
        return {16'((mi * (1 << sh)) % 65536), 8'(ei - sh), 1'b0, (lz > ei)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic logic [31:0] outs();
        return 32'({out_mant, out_exp, out_zero, out_tiny});
    endfunction

    task automatic drive();
        if (src.size() > 0) begin
            in_valid = 1'b1;
            {in_mant, in_exp} = src[0];
        end else begin
            in_valid = 1'b0;
            in_mant  = '0;
            in_exp   = '0;
        end
    endtask

    // One clock: record handshakes mid-cycle, then advance and redrive.
    task automatic tick();
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
            else begin
                check("result", outs(), 32'(sb[0]));
                void'(sb.pop_front());
                popped++;
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(model(in_mant, in_exp));
            void'(src.pop_front());
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while ((sb.size() > 0 || src.size() > 0) && cycles < budget) begin
            tick();
            cycles++;
        end
        check("drain_left", 32'(sb.size() + src.size()), 32'd0);
    endtask

    initial begin
        logic [23:0] vin  [4];
        logic [25:0] vexp [4];
        int n;
        int acc;
        int p0;
        logic [15:0] m;
        logic [7:0]  e;

        vin[0] = {16'h00F0, 8'd20};  vexp[0] = {16'hF000, 8'd12, 1'b0, 1'b0};
        vin[1] = {16'h0001, 8'd3};   vexp[1] = {16'h0008, 8'd0,  1'b0, 1'b1};
        vin[2] = {16'h0000, 8'd77};  vexp[2] = {16'h0000, 8'd0,  1'b1, 1'b0};
        vin[3] = {16'h8001, 8'd0};   vexp[3] = {16'h8001, 8'd0,  1'b0, 1'b0};

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outs", outs(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: two-cycle latency and literal results.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src.push_back(vin[i]);
            drive();
            tick();
            check("lat_cycle1_valid", 32'(out_valid), 32'd0);
            tick();
            check("lat_cycle2_valid", 32'(out_valid), 32'd1);
            check("directed_result", outs(), 32'(vexp[i]));
            drain(10, n);
        end

        // Full throughput: N operands drain in N+2 cycles.
        for (int i = 0; i < 4; i++) src.push_back(vin[i]);
        src.push_back({16'h1234, 8'd2});
        src.push_back({16'h0003, 8'd200});
        drive();
        drain(50, n);
        check("throughput_cycles", 32'(n), 32'd8);

        // Backpressure: four operands offered while out_ready is low.
        out_ready = 1'b0;
        p0 = popped;
        src.push_back({16'h0F00, 8'd9});
        src.push_back({16'h0002, 8'd4});
        src.push_back({16'h4000, 8'd1});
        src.push_back({16'h0100, 8'd30});
        drive();
        for (int c = 0; c < 5; c++) begin
            tick();
            acc = 4 - src.size();
            if (acc >= 2) check("bp_in_ready", 32'(in_ready), 32'd0);
            if (out_valid) check("bp_hold", outs(), 32'(sb[0]));
        end
        check("bp_accepts", 32'(4 - src.size()), 32'd2);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain(50, n);
        check("bp_results", 32'(popped - p0), 32'd4);

        // Reset with two results in flight.
        out_ready = 1'b0;
        src.push_back({16'h00FF, 8'd40});
        src.push_back({16'h0010, 8'd5});
        drive();
        tick();
        tick();
        check("mid_inflight", 32'(sb.size()), 32'd2);
        check("mid_out_valid_pre", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_outs", outs(), 32'd0);
        sb.delete();
        src.delete();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("mid_post_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized operands with random backpressure.
        for (int i = 0; i < 200; i++) begin
            m = 16'($urandom) >> $urandom_range(0, 16);
            if ($urandom_range(0, 19) == 0) m = '0;
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 18));
            src.push_back({m, e});
        end
        drive();
        n = 0;
        while ((sb.size() > 0 || src.size() > 0) && n < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        drain(20, n);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
